sim_run_ctrl: RTL and testbench
===============================

# sim_run_ctrl

Parametrised simulation run controller that sits between the test bench and the `cpu` instance. It sequences the CPU reset, counts run cycles, and ends the run on a halt write or a cycle-budget timeout. It records the last `TRACE_DEPTH` bus writes in a ring buffer, and reports pass, fail or timeout as registered flags. It replaces fixed-delay `#N`/`$finish` run control with a cycle-exact, parametrised one.

## Interface
- `RESET_CYCLES`, default 2: cycles `cpu_rst` is held high after `rst` deasserts; legal range ≥1.
- `MAX_CYCLES`, default 200: RUN-cycle budget before timeout; legal range ≥1.
- `ADDR_W`, default 16: monitored write-address width.
- `DATA_W`, default 16: monitored write-data width.
- `HALT_ADDR`, default 16'hFFFF: write address that ends the run.
- `PASS_VALUE`, default 1: halt data value meaning pass.
- `TRACE_DEPTH`, default 8: number of trace entries; must be a power of two and ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cpu_rst` output 1: reset driven to the CPU.
- `wr_en` input 1: CPU memory write strobe, sampled on `clk`.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input DATA_W: write data.
- `sim_end` output 1: run finished; sticky until `rst`.
- `pass` output 1: halt write carried `PASS_VALUE`.
- `fail` output 1: halt write carried any other value.
- `timeout` output 1: budget exhausted with no halt write.
- `cycle_count` output 32: number of RUN cycles elapsed.
- `trace_idx` input log2(TRACE_DEPTH): trace read index; 0 is the oldest stored entry.
- `trace_addr` output ADDR_W: address field of the selected entry; combinational read.
- `trace_data` output DATA_W: data field of the selected entry; combinational read.
- `trace_count` output log2(TRACE_DEPTH)+1: number of valid entries; saturates at TRACE_DEPTH.

## Operation
- States: HOLD, RUN, DONE. `rst` high forces HOLD asynchronously.
- HOLD:
  - `cpu_rst`=1; the hold counter increments each edge.
  - On the edge where the counter reaches `RESET_CYCLES`-1, move to RUN and set `cpu_rst` to 0.
- RUN:
  - `cycle_count` increments every edge.
  - A write with `wr_en`=1 and `wr_addr`≠`HALT_ADDR` is pushed into the trace.
  - A write with `wr_en`=1 and `wr_addr`==`HALT_ADDR` is also pushed into the trace. It moves to DONE and sets `pass` or `fail` according to `wr_data`==`PASS_VALUE`.
  - Otherwise, if `cycle_count`==`MAX_CYCLES`-1 on the edge, move to DONE and set `timeout`.
  - If a halt write and budget exhaustion occur on the same edge, the halt wins and `timeout` stays 0.
- DONE:
  - `sim_end`=1 and `cpu_rst`=1, so the CPU is frozen.
  - `cycle_count`, trace contents and flags are frozen; `wr_en` is ignored.
  - Only `rst` leaves DONE.
- Trace ring:
  - Write pointer `wp` wraps modulo `TRACE_DEPTH`.
  - Once full, a new write overwrites the oldest entry; `trace_count` stays at `TRACE_DEPTH`.
  - Read slot = (`wp` − `trace_count` + `trace_idx`) mod `TRACE_DEPTH`.
  - A `trace_idx` ≥ `trace_count` returns all zeros.
- Exactly one of `pass`, `fail`, `timeout` is 1 whenever `sim_end`=1; all three are 0 otherwise.
- Reset mid-run: every register returns to its reset value immediately, the trace is emptied, and HOLD restarts.

## Timing
- Reset values:
  - `cpu_rst`=1.
  - `sim_end`=0, `pass`=0, `fail`=0, `timeout`=0.
  - `cycle_count`=0, `trace_count`=0, `wp`=0.
  - Trace RAM cleared to 0.
- `cpu_rst` falls on rising edge number `RESET_CYCLES` after `rst` deasserts (edges counted from 1).
- The halt write is sampled on edge k. On edge k:
  - `sim_end` and `pass`/`fail` rise.
  - `cpu_rst` rises.
  - `cycle_count` shows its value before edge k + 1.
  - `trace_count` includes the halt entry.
- Timeout: `sim_end` and `timeout` rise on the edge where `cycle_count` becomes `MAX_CYCLES`.
- Trace read latency: combinational from `trace_idx`; updates one edge after a push.
- `cycle_count` saturates at 2^32−1. This is unreachable while `MAX_CYCLES` < 2^32.

## Test plan
- **Reset sequencing:** `RESET_CYCLES`=2, release `rst`.
  - `cpu_rst` stays 1 for 2 edges, then reads 0.
  - `cycle_count`=0 at the first RUN edge.
- **Pass:** write 0x0001 to 0xFFFF on RUN cycle 10.
  - `sim_end`=1, `pass`=1, `fail`=0, `timeout`=0.
  - `cycle_count`=11; `cpu_rst`=1 from the same edge.
- **Fail:** write 0x00EE to 0xFFFF.
  - `fail`=1, `pass`=0.
  - Trace newest entry = {0xFFFF, 0x00EE}.
- **Timeout:** `MAX_CYCLES`=20, no halt write.
  - `timeout`=1 and `cycle_count`=20 at the 20th RUN edge.
  - Later writes are ignored and `trace_count` is unchanged.
- **Trace wrap:** `TRACE_DEPTH`=8, 11 writes with addr=i, data=0x100+i for i=0..10.
  - `trace_count`=8.
  - `trace_idx` 0 → {3, 0x103}; `trace_idx` 7 → {10, 0x10A}.
- **Simultaneous events and reset:**
  - A halt write on edge `MAX_CYCLES`-1 gives `pass`=1 and `timeout`=0.
  - Asserting `rst` mid-RUN immediately clears all flags and the trace, and sets `cpu_rst`=1.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: sequences CPU reset, counts run cycles,
// ends the run on a halt write or budget timeout, and keeps a write trace.
module sim_run_ctrl #(
   parameter int unsigned RESET_CYCLES = 2,
   parameter int unsigned MAX_CYCLES   = 200,
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned DATA_W       = 16,
   parameter logic [ADDR_W-1:0] HALT_ADDR  = 16'hFFFF,
   parameter logic [DATA_W-1:0] PASS_VALUE = DATA_W'(1),
   parameter int unsigned TRACE_DEPTH  = 8,
   localparam int unsigned IDX_W       = $clog2(TRACE_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              cpu_rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              sim_end,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [31:0]       cycle_count,
   input  logic [IDX_W-1:0]  trace_idx,
   output logic [ADDR_W-1:0] trace_addr,
   output logic [DATA_W-1:0] trace_data,
   output logic [IDX_W:0]    trace_count
);

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(TRACE_DEPTH);

   typedef enum logic [1:0] {
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_hold_cnt;
   logic [31:0]       r_cycle_cnt;
   logic              r_pass;
   logic              r_fail;
   logic              r_timeout;
   logic [IDX_W-1:0]  r_wp;
   logic [IDX_W:0]    r_tcnt;
   logic [ADDR_W-1:0] r_taddr [TRACE_DEPTH];
   logic [DATA_W-1:0] r_tdata [TRACE_DEPTH];

   logic              w_push;
   logic              w_halt;
   logic              w_tmo;
   logic              w_cpu_rst;
   logic              w_sim_end;
   logic              w_is_halt;
   logic [IDX_W-1:0]  w_slot;
   logic              w_idx_ok;

   assign w_is_halt = wr_en && (wr_addr == HALT_ADDR);

   // State register; reset forces HOLD immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_HOLD;
      else     r_state <= w_next;
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      w_next    = r_state;
      w_push    = 1'b0;
      w_halt    = 1'b0;
      w_tmo     = 1'b0;
      w_cpu_rst = 1'b1;
      w_sim_end = 1'b0;
      unique case (r_state)
         S_HOLD: begin
            if (r_hold_cnt == RESET_CYCLES - 1) w_next = S_RUN;
         end
         S_RUN: begin
            w_cpu_rst = 1'b0;
            w_push    = wr_en;
            if (w_is_halt) begin
               w_halt = 1'b1;
               w_next = S_DONE;
            end else if (r_cycle_cnt == MAX_CYCLES - 1) begin
               w_tmo  = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_sim_end = 1'b1;
         end
         default: w_next = S_HOLD;
      endcase
   end

   // Hold counter and saturating run-cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt  <= '0;
         r_cycle_cnt <= '0;
      end else begin
         if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt + 32'd1;
         if (r_state == S_RUN && r_cycle_cnt != '1)
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   // Result flags, set once on the edge that ends the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_halt) begin
         r_pass <= (wr_data == PASS_VALUE);
         r_fail <= (wr_data != PASS_VALUE);
      end else if (w_tmo) begin
         r_timeout <= 1'b1;
      end
   end

   // Trace ring: oldest entry is overwritten once full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp   <= '0;
         r_tcnt <= '0;
         for (int i = 0; i < TRACE_DEPTH; i++) begin
            r_taddr[i] <= '0;
            r_tdata[i] <= '0;
         end
      end else if (w_push) begin
         r_taddr[r_wp] <= wr_addr;
         r_tdata[r_wp] <= wr_data;
         r_wp          <= r_wp + 1'b1;
         if (r_tcnt != FULL_CNT) r_tcnt <= r_tcnt + 1'b1;
      end
   end

   // Combinational trace read relative to the oldest valid entry.
   always_comb begin
      w_slot   = r_wp - r_tcnt[IDX_W-1:0] + trace_idx;
      w_idx_ok = ({1'b0, trace_idx} < r_tcnt);
   end

   assign trace_addr  = w_idx_ok ? r_taddr[w_slot] : '0;
   assign trace_data  = w_idx_ok ? r_tdata[w_slot] : '0;
   assign trace_count = r_tcnt;
   assign cpu_rst     = w_cpu_rst;
   assign sim_end     = w_sim_end;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign timeout     = r_timeout;
   assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed run scenarios with random writes,
// checked every cycle against a queue-based model of the run.
module tb_sim_run_ctrl;

   localparam int RC  = 2;
   localparam int MC  = 20;
   localparam int TD  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_rst;
   logic        wr_en = 1'b0;
   logic [15:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        sim_end, pass, fail, timeout;
   logic [31:0] cycle_count;
   logic [2:0]  trace_idx = '0;
   logic [15:0] trace_addr, trace_data;
   logic [3:0]  trace_count;

   int tests = 0;
   int fails = 0;

   // model of the run
   int          m_phase;  // 0 hold, 1 run, 2 done
   int          m_edges;
   int          m_cyc;
   bit          m_pass, m_fail, m_tmo;
   logic [31:0] m_q[$];

   sim_run_ctrl #(
      .RESET_CYCLES(RC),
      .MAX_CYCLES  (MC),
      .TRACE_DEPTH (TD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_rst    (cpu_rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .sim_end    (sim_end),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .cycle_count(cycle_count),
      .trace_idx  (trace_idx),
      .trace_addr (trace_addr),
      .trace_data (trace_data),
      .trace_count(trace_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_edges = 0;
      m_cyc   = 0;
      m_pass  = 0;
      m_fail  = 0;
      m_tmo   = 0;
      m_q.delete();
   endtask

   task automatic model_edge(input bit en, input logic [15:0] a,
                             input logic [15:0] d);
      if (m_phase == 0) begin
         m_edges++;
         if (m_edges == RC) m_phase = 1;
      end else if (m_phase == 1) begin
         m_cyc++;
         if (en) begin
            m_q.push_back({a, d});
            if (m_q.size() > TD) void'(m_q.pop_front());
         end
         if (en && a == 16'hFFFF) begin
            m_phase = 2;
            m_pass  = (d == 16'h0001);
            m_fail  = (d != 16'h0001);
         end else if (m_cyc == MC) begin
            m_phase = 2;
            m_tmo   = 1;
         end
      end
   endtask

   task automatic chk_trace(input string tag, input int idx,
                            input logic [15:0] ea, input logic [15:0] ed);
      trace_idx = 3'(idx);
      #1;
      chk({tag, "_addr"}, 32'(trace_addr), 32'(ea));
      chk({tag, "_data"}, 32'(trace_data), 32'(ed));
   endtask

   task automatic chk_all();
      int          idx;
      logic [31:0] e;
      chk("cpu_rst", 32'(cpu_rst), 32'(m_phase != 1));
      chk("sim_end", 32'(sim_end), 32'(m_phase == 2));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("timeout", 32'(timeout), 32'(m_tmo));
      chk("cycle_count", cycle_count, 32'(m_cyc));
      chk("trace_count", 32'(trace_count), 32'(m_q.size()));
      idx = $urandom_range(0, TD - 1);
      e   = (idx < m_q.size()) ? m_q[idx] : 32'h0;
      chk_trace("trace_rd", idx, e[31:16], e[15:0]);
   endtask

   task automatic step(input bit en, input logic [15:0] a,
                       input logic [15:0] d);
      wr_en   = en;
      wr_addr = a;
      wr_data = d;
      @(posedge clk);
      model_edge(en, a, d);
      #1;
      chk_all();
   endtask

   task automatic step_rand();
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFE)),
           16'($urandom));
   endtask

   task automatic restart();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      chk_all();
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0);
      step(0, 0, 0);
   endtask

   initial begin
      model_reset();
      // reset state and release
      #2;
      chk_all();
      @(negedge clk);
      rst = 1'b0;
      step_rand();
      chk("hold_edge1", 32'(cpu_rst), 32'd1);
      step_rand();
      chk("run_edge2", 32'(cpu_rst), 32'd0);
      chk("run_cyc0", cycle_count, 32'd0);

      // pass: halt write on run cycle 10
      for (int i = 0; i < 10; i++) step_rand();
      step(1, 16'hFFFF, 16'h0001);
      chk("pass_flag", 32'(pass), 32'd1);
      chk("pass_cyc", cycle_count, 32'd11);
      chk("pass_cpu_rst", 32'(cpu_rst), 32'd1);
      for (int i = 0; i < 4; i++) step(1, 16'h0042, 16'($urandom));

      // trace wrap then fail halt
      restart();
      for (int i = 0; i <= 10; i++) step(1, 16'(i), 16'(16'h100 + i));
      chk("wrap_cnt", 32'(trace_count), 32'd8);
      chk_trace("wrap_old", 0, 16'd3, 16'h103);
      chk_trace("wrap_new", 7, 16'd10, 16'h10A);
      step(1, 16'hFFFF, 16'h00EE);
      chk("fail_flag", 32'(fail), 32'd1);
      chk("fail_pass", 32'(pass), 32'd0);
      chk_trace("fail_new", 7, 16'hFFFF, 16'h00EE);

      // timeout with no halt write
      restart();
      for (int i = 0; i < MC; i++) step_rand();
      chk("tmo_flag", 32'(timeout), 32'd1);
      chk("tmo_cyc", cycle_count, 32'(MC));
      for (int i = 0; i < 5; i++) step(1, 16'h0010, 16'($urandom));
      chk("tmo_frozen_cnt", 32'(trace_count), 32'(m_q.size()));

      // halt on the last budget cycle beats timeout
      restart();
      for (int i = 0; i < MC - 1; i++) step_rand();
      step(1, 16'hFFFF, 16'h0001);
      chk("race_pass", 32'(pass), 32'd1);
      chk("race_tmo", 32'(timeout), 32'd0);

      // asynchronous reset mid-run
      restart();
      for (int i = 0; i < 6; i++) step(1, 16'($urandom_range(0, 100)),
                                       16'($urandom));
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("arst_tcnt", 32'(trace_count), 32'd0);
      chk("arst_cyc", cycle_count, 32'd0);
      chk_all();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step_rand();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
